// File: rtl/unary_reduce_sequencer.sv
// Multi-cycle OR/AND/XOR reduction of a W-bit operand through one shared N-bit datapath.
// Optional early termination for OR/AND when `UNARY_REDUCE_EARLY_EXIT_EN is defined.
module unary_reduce_sequencer #(
  parameter int W = 64,
  parameter int N = 8,
  localparam int CHUNKS = W / N,
  localparam int CW = $clog2(CHUNKS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [W-1:0]  in_a,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_c,
  output logic [CW-1:0] out_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [W-1:0]    sreg_r;
  logic [1:0]      op_r;
  logic            acc_r;
  logic [CW-1:0]   idx_r;
  logic            out_valid_r;
  logic            out_c_r;
  logic [CW-1:0]   out_cycles_r;

  logic            red_s;
  logic            acc_next_s;
  logic            last_s;
  logic            exit_s;

  function automatic logic reduce_chunk(input logic [N-1:0] chunk, input logic [1:0] op);
    logic r;
    case (op)
      2'd1:    r = &chunk;
      2'd2:    r = ^chunk;
      default: r = |chunk;
    endcase
    return r;
  endfunction

  function automatic logic combine(input logic acc, input logic r, input logic [1:0] op);
    logic c;
    case (op)
      2'd1:    c = acc & r;
      2'd2:    c = acc ^ r;
      default: c = acc | r;
    endcase
    return c;
  endfunction

  // Per-cycle reduction of the low chunk and the decision to leave RUN
  always_comb begin
    red_s      = reduce_chunk(sreg_r[N-1:0], op_r);
    acc_next_s = combine(acc_r, red_s, op_r);
    last_s     = (idx_r == CW'(CHUNKS - 1));
`ifdef UNARY_REDUCE_EARLY_EXIT_EN
    if (op_r == 2'd1) begin
      exit_s = last_s || !acc_next_s;
    end else if (op_r == 2'd2) begin
      exit_s = last_s;
    end else begin
      exit_s = last_s || acc_next_s;
    end
`else
    exit_s = last_s;
`endif
  end

  // Sequencer FSM with registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      sreg_r       <= '0;
      op_r         <= 2'd0;
      acc_r        <= 1'b0;
      idx_r        <= '0;
      out_valid_r  <= 1'b0;
      out_c_r      <= 1'b0;
      out_cycles_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            sreg_r  <= in_a;
            // Reserved op 3 is folded to OR here so the datapath only sees 0..2
            op_r    <= (in_op == 2'd3) ? 2'd0 : in_op;
            acc_r   <= (in_op == 2'd1);
            idx_r   <= '0;
            state_r <= RUN;
          end
        end
        RUN: begin
          acc_r  <= acc_next_s;
          sreg_r <= sreg_r >> N;
          idx_r  <= idx_r + CW'(1);
          if (exit_s) begin
            state_r      <= DONE;
            out_valid_r  <= 1'b1;
            out_c_r      <= acc_next_s;
            out_cycles_r <= idx_r + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = (state_r == IDLE);
  assign out_valid  = out_valid_r;
  assign out_c      = out_c_r;
  assign out_cycles = out_cycles_r;

endmodule

// File: tb/tb_unary_reduce_sequencer.sv
// Directed-vector bench for unary_reduce_sequencer at W=32, N=8 (4 chunks).
module tb_unary_reduce_sequencer;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = 2'd0;
  logic [W-1:0]  in_a = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_c;
  logic [CW-1:0] out_cycles;

  int vectors = 0;
  int miscompares = 0;

  unary_reduce_sequencer #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_cycles(out_cycles)
  );

  always #5 clk = ~clk;

`ifdef UNARY_REDUCE_EARLY_EXIT_EN
  localparam int AND_EXIT_CYC = 1;
  localparam int OP3_CYC = 1;
`else
  localparam int AND_EXIT_CYC = 4;
  localparam int OP3_CYC = 4;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (out_valid !== 1'b1) chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  // Full request/response with immediate consumption of the result
  task automatic run_req(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic exp_c, input int exp_cyc);
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    tick();
    in_valid = 1'b0;
    wait_out_valid(tag);
    chk({tag, "_c"}, 32'(out_c), 32'(exp_c));
    chk({tag, "_cyc"}, 32'(out_cycles), 32'(exp_cyc));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_c", 32'(out_c), 32'd0);
    chk("rst_out_cycles", 32'(out_cycles), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_req("or_zero", 2'd0, 32'h0000_0000, 1'b0, 4);
    run_req("or_top",  2'd0, 32'h0100_0000, 1'b1, 4);
    run_req("and_ones", 2'd1, 32'hFFFF_FFFF, 1'b1, 4);
    run_req("and_low0", 2'd1, 32'hFFFF_FF7F, 1'b0, AND_EXIT_CYC);
    run_req("xor_even", 2'd2, 32'h8000_0001, 1'b0, 4);
    run_req("xor_odd",  2'd2, 32'h0001_0000, 1'b1, 4);

    // Backpressure: result must hold while out_ready is low
    in_valid = 1'b1; in_op = 2'd2; in_a = 32'h0000_0700;
    tick();
    in_valid = 1'b0;
    wait_out_valid("bp");
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_c", 32'(out_c), 32'd1);
      chk("bp_cyc", 32'(out_cycles), 32'd4);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_rel_valid", 32'(out_valid), 32'd0);
    chk("bp_rel_in_ready", 32'(in_ready), 32'd1);

    // Reset during the second RUN cycle discards the request
    in_valid = 1'b1; in_op = 2'd0; in_a = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst_no_result", 32'(out_valid), 32'd0);
    end
    run_req("post_rst", 2'd0, 32'h0100_0000, 1'b1, 4);

    // Back-to-back with reserved op and consumer always ready
    in_valid = 1'b1; in_op = 2'd3; in_a = 32'h0000_0010; out_ready = 1'b1;
    tick();
    chk("b2b_acc1", 32'(in_ready), 32'd0);
    wait_out_valid("b2b1");
    chk("b2b1_c", 32'(out_c), 32'd1);
    chk("b2b1_cyc", 32'(out_cycles), 32'(OP3_CYC));
    chk("b2b1_in_ready_done", 32'(in_ready), 32'd0);
    tick();
    chk("b2b_idle_ready", 32'(in_ready), 32'd1);
    chk("b2b_idle_valid", 32'(out_valid), 32'd0);
    tick();
    chk("b2b_acc2", 32'(in_ready), 32'd0);
    wait_out_valid("b2b2");
    chk("b2b2_c", 32'(out_c), 32'd1);
    chk("b2b2_cyc", 32'(out_cycles), 32'(OP3_CYC));
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("b2b_end_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
